// File: rtl/seq_alu_if.sv
// Operand/result bundle and start/busy/done handshake between the requester and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 18
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] tr_in;
  logic [WIDTH-1:0] ac_in;
  logic [WIDTH-1:0] result;
  logic             z_flag;
  logic             c_flag;
  logic             busy;
  logic             done;

  modport master (
    output start, op, tr_in, ac_in,
    input  result, z_flag, c_flag, busy, done
  );

  modport slave (
    input  start, op, tr_in, ac_in,
    output result, z_flag, c_flag, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU downstream of TR: single-cycle logic/add/sub ops and a
// WIDTH-iteration shift-add multiply, with registered result and z/c flags.
module seq_alu #(
  parameter int WIDTH = 18,
  parameter int CNTW  = 5
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, partial_q, result_q, mul_sum;
  logic [CNTW-1:0]  cnt_q;
  logic             z_q, c_q, mul_last;

  // Returns {carry, result}; the extra top bit carries add carry-out, sub borrow or shift-out.
  function automatic logic [WIDTH:0] alu_eval(input logic [2:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (o)
      OP_PASS: r = {1'b0, b};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_SHL:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_SHR:  r = {a[0], 1'b0, a[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign mul_sum  = partial_q + (b_q[0] ? a_q : '0);
  assign mul_last = (cnt_q == CNTW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.op == OP_MUL) ? MUL : EXEC;
      EXEC: state_nxt = DONE;
      MUL:  if (mul_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q      <= bus.op;
          a_q       <= bus.ac_in;
          b_q       <= bus.tr_in;
          partial_q <= '0;
          cnt_q     <= '0;
        end
        EXEC: begin
          {c_q, result_q} <= alu_eval(op_q, a_q, b_q);
          z_q             <= (alu_eval(op_q, a_q, b_q) & {1'b0, {WIDTH{1'b1}}}) == '0;
        end
        MUL: begin
          partial_q <= mul_sum;
          a_q       <= a_q << 1;
          b_q       <= b_q >> 1;
          cnt_q     <= cnt_q + 1'b1;
          // The final iteration's addition is folded directly into the result.
          if (mul_last) begin
            result_q <= mul_sum;
            z_q      <= (mul_sum == '0);
            c_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.z_flag = z_q;
  assign bus.c_flag = c_q;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle ALU stage directly downstream of the temporary register (TR).
- Consumes TR's 18-bit output as operand B and the accumulator value as operand A.
- Produces a registered 18-bit result plus zero and carry flags, under a start/busy/done handshake.
- Logic and add/sub ops complete in a fixed short latency. Multiply is an iterative shift-add over WIDTH cycles.

Parameters:
WIDTH, 18, datapath width (matches TR output width)
CNTW, 5, iteration counter width; must satisfy 2**CNTW > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request operation; sampled only in IDLE
op  input  3  operation select, latched with start
tr_in  input  WIDTH  operand B, from TR dout
ac_in  input  WIDTH  operand A, from accumulator
result  output  WIDTH  registered result; holds until the next completion
z_flag  output  1  1 when the last completed result == 0
c_flag  output  1  carry/borrow/shift-out of the last completed op
busy  output  1  1 from start acceptance until the done cycle ends
done  output  1  one-cycle pulse: result and flags valid/updated

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; result=0, z_flag=0, c_flag=0, busy=0, done=0; internal counter and operand registers cleared. Reset overrides any in-flight op; no done pulse follows.
- States: IDLE, EXEC, MUL, DONE.
- IDLE, start=1 sampled at edge k:
  - Latch op, A=ac_in, B=tr_in; set busy=1.
  - Go to MUL (op=011, count=0, partial=0); otherwise go to EXEC.
  - Operand inputs may change after edge k without effect.
- EXEC, edge k+1:
  - Write result, z_flag, c_flag; done=1; go to DONE.
- MUL, each edge:
  - If B[0], partial += A (WIDTH bits, carry discarded).
  - A <<= 1; B >>= 1; count++.
  - On the edge where count reaches WIDTH-1 (the WIDTH-th iteration, edge k+WIDTH): result = final partial, flags written, done=1, go to DONE.
- DONE, next edge: done=0, busy=0, go to IDLE.
  - done is high exactly one cycle; busy falls on the same edge as done.
- Timing:
  - Non-MUL latency: done visible 1 cycle after acceptance; a new start may be accepted 2 edges after done rises.
  - MUL latency: WIDTH cycles.
- start while busy (EXEC/MUL/DONE): ignored, no queuing.
- Ops, all arithmetic mod 2**WIDTH:
  - 000 PASS: result=B; c=0.
  - 001 ADD: result=A+B; c=carry out of bit WIDTH-1.
  - 010 SUB: result=A-B; c=1 iff A<B unsigned (borrow).
  - 011 MUL: result=low WIDTH bits of A*B; c=0.
  - 100 AND: A&B; c=0.
  - 101 OR: A|B; c=0.
  - 110 SHL: A<<1; c=A[WIDTH-1].
  - 111 SHR: A>>1 logical; c=A[0].
- z_flag = (new result == 0), updated only on completion.
- result and flags are stable between completions and unaffected by input activity.

Test Plan:
- Reset then ADD: ac_in=0x0000B, tr_in=0x0000F, op=001, start for 1 cycle -> 1 cycle later done=1, result=0x0001A, z=0, c=0; busy high for 2 cycles.
- SUB borrow: A=5, B=7, op=010 -> result=0x3FFFE, c=1, z=0.
- ADD wrap: A=0x3FFFF, B=0x00001 -> result=0x00000, z=1, c=1.
- MUL: A=11, B=15, op=011 -> done asserts exactly 18 cycles after acceptance; result=0x000A5, c=0. Start pulses during busy are ignored: exactly one done, and the result is unchanged.
- Reset mid-MUL: assert rst at cycle 9 of a MUL -> next cycle busy=0, done=0, result=0. No done appears afterward. A following PASS with B=0x12345 gives result=0x12345.
- SHL/SHR: A=0x20001 -> SHL result=0x00002, c=1; SHR result=0x10000, c=1. Back-to-back PASS ops return to IDLE between them (done spacing of 3 cycles).
